wishbone_manager: RTL

- Memory-side responder to the request handler. It accepts the handler's single-word mem_read/mem_write request (adr_to_mem, data_to_mem, sel_to_mem) and runs one classic Wishbone single-read or single-write cycle.
- Read data returns on data_from_mem; transaction progress is reported on mem_busy.
- Sits between the request handler and the SoC Wishbone bus; it is the manager end of the handler's memory interface.

---
 rtl/mem_if_pkg.sv | 10 +
 rtl/wb_timeout_counter.sv | 35 +++
 rtl/wishbone_manager.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared types and defaults for the request-handler to Wishbone memory interface.
package mem_if_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } mem_state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBAD0_BAD0;
    localparam int          TIMEOUT_DEFAULT  = 255;
endpackage

// File: rtl/wb_timeout_counter.sv
// 8-bit saturating cycle counter; hit flags that the bus has waited TIMEOUT cycles.
module wb_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       clr,
    input  logic       en,
    output logic [7:0] cnt,
    output logic       hit
);
    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (nRst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign hit = (cnt_q == LIMIT);
endmodule

// File: rtl/wishbone_manager.sv
// Turns a single-word mem_read/mem_write request into one classic Wishbone cycle,
// returning read data, bus errors and timeouts to the request handler.
module wishbone_manager
    import mem_if_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = TIMEOUT_DEFAULT,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_W-1:0]     adr_to_mem,
    input  logic [DATA_W-1:0]     data_to_mem,
    input  logic [DATA_W/8-1:0]   sel_to_mem,
    output logic [DATA_W-1:0]     data_from_mem,
    output logic                  mem_busy,
    output logic                  mem_err,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_W-1:0]     wb_adr_o,
    output logic [DATA_W-1:0]     wb_dat_o,
    output logic [DATA_W/8-1:0]   wb_sel_o,
    input  logic [DATA_W-1:0]     wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i
);
    localparam int SEL_W = DATA_W / 8;

    mem_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic       in_bus;
    logic [7:0] tmo_cnt;
    logic       tmo_hit;

    assign in_bus = (state_q == BUS);

    // Cleared throughout IDLE so every transaction starts counting from zero.
    wb_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk (clk),
        .nRst(nRst),
        .clr (!in_bus),
        .en  (in_bus),
        .cnt (tmo_cnt),
        .hit (tmo_hit)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_write || mem_read) begin
                    we_d    = mem_write;
                    adr_d   = adr_to_mem;
                    dat_d   = data_to_mem;
                    sel_d   = sel_to_mem;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wb_ack_i) begin
                    if (!we_q) rdata_d = wb_dat_i;
                    state_d = IDLE;
                end else if (wb_err_i || tmo_hit) begin
                    if (!we_q) rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nRst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Bus outputs are gated by state so they read as zero whenever IDLE.
    assign wb_cyc_o = in_bus;
    assign wb_stb_o = in_bus;
    assign wb_we_o  = in_bus & we_q;
    assign wb_adr_o = in_bus ? adr_q : '0;
    assign wb_dat_o = in_bus ? dat_q : '0;
    assign wb_sel_o = in_bus ? sel_q : '0;

    assign data_from_mem = rdata_q;
    assign mem_err       = err_q;
    assign mem_busy      = in_bus | (mem_read | mem_write);

    logic unused_cnt;
    assign unused_cnt = ^tmo_cnt;
endmodule
